muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit, downstream of the ALU operand-B source mux.
//  Operand A comes from register rs1; operand B is the mux result (always rs2 for M-ops).
//  Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU with fixed XLEN+1-cycle latency.
//  While busy=1 the core stalls the PC.
// PARAMETERS
//  XLEN  32  operand/result width; iteration count equals XLEN
// PORTS
//  clk     in   1     rising-edge clock
//  reset   in   1     synchronous, active-high reset
//  start   in   1     request; sampled only in IDLE
//  funct3  in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  opA     in   XLEN  rs1 value, captured at accepted start
//  opB     in   XLEN  operand from bottom mux, captured at accepted start
//  busy    out  1     1 in CALC and DONE states
//  done    out  1     1-cycle pulse; result valid in that cycle
//  result  out  XLEN  last completed result, held until next completion
// BEHAVIOUR
//  Reset (sync, active-high): state=IDLE, busy=0, done=0, result=0, iteration counter=0.
//   Reset mid-operation aborts; no done pulse is produced.
//  FSM: IDLE -(start)-> CALC -(counter==XLEN-1)-> DONE -> IDLE (unconditional).
//  Accept: at a clk edge with state==IDLE && start==1:
//   - latch funct3, sign flags and |opA|, |opB|; clear counter.
//   - signed operands are MULH (A and B), MULHSU (A only), DIV/REM (A and B).
//  CALC: one iteration per cycle, XLEN cycles.
//   - Multiply: shift-add over a 2*XLEN accumulator.
//   - Divide: restoring shift-subtract producing quotient and remainder.
//  Transition into DONE:
//   - apply sign correction and register the selected output into result.
//   - MUL takes the low word; MULH/MULHSU/MULHU take the high word.
//  Latency: start accepted at edge of cycle 0 -> done=1 during cycle XLEN+1
//   (33 for XLEN=32); back-to-back start earliest in cycle XLEN+2.
//  start while busy=1 is ignored (not queued); opA/opB changes while busy have no effect.
//  Sign rules:
//   - product negative iff signed-effective signs differ;
//   - quotient sign = sA^sB; remainder sign = sign of dividend (truncating division).
//  Divide by zero (opB==0):
//   - quotient = all ones (both DIV and DIVU); remainder = original opA;
//   - sign correction suppressed.
//  Signed overflow: DIV 0x80000000 / 0xFFFFFFFF = 0x80000000; REM = 0.
//   - magnitude path yields this naturally and needs no special case.
//  All arithmetic is unsigned on magnitudes; |x| of 0x80000000 is 0x80000000 read as unsigned.
//  No exceptions or flags; result unchanged by reset-free idle cycles.
// TESTING
//  1 MUL 7 * 0xFFFFFFFD, start at cycle 0 -> done only at cycle 33, result=0xFFFFFFEB, busy 1..33
//  2 MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000
//  3 MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF
//  4 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF
//  5 DIVU 0x1234 / 0 -> 0xFFFFFFFF; REM 0xFFFFFFF9 / 0 -> 0xFFFFFFF9;
//    DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same -> 0
//  6 start pulses at cycles 5 and 20 during busy -> ignored, one done only;
//    reset at cycle 10 -> IDLE, no done, result=0

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring shift-subtract
// step per cycle on operand magnitudes, sign correction applied on the way into DONE.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] opa_i,
    input  logic [XLEN-1:0] opb_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          funct3_q, funct3_d;
    logic                neg_a_q, neg_a_d;
    logic                neg_b_q, neg_b_d;
    logic                b_zero_q, b_zero_d;
    logic [XLEN-1:0]     mag_q, mag_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     result_q, result_d;

    // Operand conditioning at accept time
    logic                signed_a, signed_b;
    logic                in_neg_a, in_neg_b;
    logic [XLEN-1:0]     in_mag_a, in_mag_b;

    always_comb begin
        signed_a = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                   (funct3_i == 3'b100) || (funct3_i == 3'b110);
        signed_b = (funct3_i == 3'b001) || (funct3_i == 3'b100) ||
                   (funct3_i == 3'b110);
        in_neg_a = signed_a & opa_i[XLEN-1];
        in_neg_b = signed_b & opb_i[XLEN-1];
        in_mag_a = in_neg_a ? (~opa_i + 1'b1) : opa_i;
        in_mag_b = in_neg_b ? (~opb_i + 1'b1) : opb_i;
    end

    // One iteration step; acc holds {hi, lo} for multiply and {rem, quotient} for divide
    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       div_shift;
    logic [XLEN:0]       div_diff;
    logic [2*XLEN-1:0]   acc_step;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                    (acc_q[0] ? {1'b0, mag_q} : {(XLEN+1){1'b0}});
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, mag_q};
        if (!funct3_q[2]) begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        end else if (!div_diff[XLEN]) begin
            acc_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            acc_step = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end
    end

    // Sign correction and output selection from the final iteration
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     quo_s;
    logic [XLEN-1:0]     rem_s;
    logic [XLEN-1:0]     final_res;

    always_comb begin
        prod_s = (neg_a_q ^ neg_b_q) ? (~acc_step + 1'b1) : acc_step;
        // Divide-by-zero keeps the all-ones quotient; remainder already equals opA
        quo_s  = ((neg_a_q ^ neg_b_q) && !b_zero_q) ?
                 (~acc_step[XLEN-1:0] + 1'b1) : acc_step[XLEN-1:0];
        rem_s  = neg_a_q ? (~acc_step[2*XLEN-1:XLEN] + 1'b1)
                         : acc_step[2*XLEN-1:XLEN];
        case (funct3_q)
            3'b000:          final_res = prod_s[XLEN-1:0];
            3'b001,
            3'b010,
            3'b011:          final_res = prod_s[2*XLEN-1:XLEN];
            3'b100,
            3'b101:          final_res = quo_s;
            default:         final_res = rem_s;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        funct3_d = funct3_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        b_zero_d = b_zero_q;
        mag_d    = mag_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_CALC;
                    cnt_d    = '0;
                    funct3_d = funct3_i;
                    neg_a_d  = in_neg_a;
                    neg_b_d  = in_neg_b;
                    b_zero_d = (opb_i == '0);
                    if (funct3_i[2]) begin
                        mag_d = in_mag_b;
                        acc_d = {{XLEN{1'b0}}, in_mag_a};
                    end else begin
                        mag_d = in_mag_a;
                        acc_d = {{XLEN{1'b0}}, in_mag_b};
                    end
                end
            end
            S_CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN-1)) begin
                    state_d  = S_DONE;
                    result_d = final_res;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            funct3_q <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            b_zero_q <= 1'b0;
            mag_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            funct3_q <= funct3_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            b_zero_q <= b_zero_d;
            mag_q    <= mag_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = (state_q == S_DONE);
    assign result_o = result_q;

endmodule
